// File: rtl/ar_request_queue.sv
// ar_request_queue
// ----------------
// In-order buffer for AXI read-address requests sitting between an upstream
// master and a BRAM read controller that only raises arready once per
// transaction. The master can keep issuing addresses while a read is in flight.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that edge.
// This queue obeys that rule on the m_ side: the head stays put until accepted.
//
// Ports:
//   clk        system clock, rising edge
//   aresetn    synchronous active-low reset
//   s_arvalid  upstream request valid
//   s_araddr   upstream request address
//   s_arready  queue can accept a request (registered)
//   m_arvalid  head request valid (registered)
//   m_araddr   head request address (registered)
//   m_arready  read controller accepts the head
//   count      current occupancy, 0..DEPTH (registered)
module ar_request_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  s_arvalid,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   output logic                  s_arready,
   output logic                  m_arvalid,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   input  logic                  m_arready,
   output logic [CNT_WIDTH-1:0]  count
);

   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr_next;
   logic [CNT_WIDTH-1:0]  count_next;
   logic                  push;
   logic                  pop;
   logic                  bypass;

   assign push = s_arvalid & s_arready;
   assign pop  = m_arvalid & m_arready;

   always_comb begin
      rd_ptr_next = rd_ptr;
      if (pop) begin
         rd_ptr_next = rd_ptr + PTR_WIDTH'(1);
      end

      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_WIDTH'(1);
         2'b01:   count_next = count - CNT_WIDTH'(1);
         default: count_next = count;
      endcase

      // The pushed entry becomes the new head when it is the only entry left
      // after this edge. Storage is not written until the edge, so the head
      // register has to take the address straight from s_araddr.
      bypass = push && (count_next == CNT_WIDTH'(1));
   end

   // Storage has no reset; its contents only matter once they are pushed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_araddr;
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         s_arready <= 1'b1;
         m_arvalid <= 1'b0;
         m_araddr  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         rd_ptr    <= rd_ptr_next;
         count     <= count_next;
         s_arready <= (count_next != CNT_WIDTH'(DEPTH));
         m_arvalid <= (count_next != '0);
         // When the queue is idle the head simply follows the slot under the
         // read pointer; nothing downstream looks at it while m_arvalid=0.
         m_araddr  <= bypass ? s_araddr : mem[rd_ptr_next];
      end
   end

endmodule

// File: tb/tb_ar_request_queue.sv
// Testbench for ar_request_queue: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model.
module tb_ar_request_queue;

   localparam int ADDR_WIDTH = 32;
   localparam int DEPTH      = 4;
   localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

   logic                  clk;
   logic                  aresetn;
   logic                  s_arvalid;
   logic [ADDR_WIDTH-1:0] s_araddr;
   logic                  s_arready;
   logic                  m_arvalid;
   logic [ADDR_WIDTH-1:0] m_araddr;
   logic                  m_arready;
   logic [CNT_WIDTH-1:0]  count;

   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;
   bit started = 0;

   logic [ADDR_WIDTH-1:0] exp_q[$];

   ar_request_queue #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .aresetn(aresetn),
      .s_arvalid(s_arvalid),
      .s_araddr(s_araddr),
      .s_arready(s_arready),
      .m_arvalid(m_arvalid),
      .m_araddr(m_araddr),
      .m_arready(m_arready),
      .count(count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   // Sampled on the falling edge: first compare the DUT against the model,
   // then apply to the model whatever happens at the coming rising edge.
   always @(negedge clk) begin
      logic mdl_ready;
      logic mdl_valid;
      logic [ADDR_WIDTH-1:0] head;
      if (started) begin
         mdl_ready = (exp_q.size() != DEPTH);
         mdl_valid = (exp_q.size() != 0);
         check("count", 64'(count), 64'(exp_q.size()));
         check("s_arready", 64'(s_arready), 64'(mdl_ready));
         check("m_arvalid", 64'(m_arvalid), 64'(mdl_valid));
         if (!aresetn) begin
            exp_q.delete();
         end else begin
            if (mdl_valid) begin
               if (m_arready) begin
                  head = exp_q.pop_front();
                  check("pop_addr", 64'(m_araddr), 64'(head));
                  pop_cnt++;
               end else begin
                  check("hold_addr", 64'(m_araddr), 64'(exp_q[0]));
               end
            end
            if (s_arvalid && mdl_ready) begin
               exp_q.push_back(s_araddr);
            end
         end
      end else if (!aresetn) begin
         exp_q.delete();
         started = 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input logic [ADDR_WIDTH-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         s_arvalid = 1'b1;
         s_araddr  = base + ADDR_WIDTH'(4 * i);
         tick();
      end
      s_arvalid = 1'b0;
   endtask

   task automatic drain();
      m_arready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) tick();
      m_arready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      aresetn   = 1'b0;
      s_arvalid = 1'b0;
      s_araddr  = '0;
      m_arready = 1'b0;
      tick();
      tick();
      check("rst_count", 64'(count), 64'd0);
      check("rst_s_arready", 64'(s_arready), 64'd1);
      check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
      check("rst_m_araddr", 64'(m_araddr), 64'd0);
      aresetn = 1'b1;
      tick();

      // Fill with the controller stalled, then try a fifth push.
      push_n(32'h100, 4);
      check("fill_count", 64'(count), 64'd4);
      check("fill_s_arready", 64'(s_arready), 64'd0);
      s_arvalid = 1'b1;
      s_araddr  = 32'h110;
      tick();
      s_arvalid = 1'b0;
      check("full_count", 64'(count), 64'd4);
      check("full_head", 64'(m_araddr), 64'h100);

      // Drain from full in four back-to-back pops.
      m_arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_head", 64'(m_araddr), 64'(32'h100 + 4 * i));
         check("drain_valid", 64'(m_arvalid), 64'd1);
         tick();
      end
      m_arready = 1'b0;
      check("drained_valid", 64'(m_arvalid), 64'd0);
      check("drained_count", 64'(count), 64'd0);
      check("drained_ready", 64'(s_arready), 64'd1);

      // Controller-style single-cycle arready pulses over 3 requests.
      push_n(32'h400, 3);
      pop_cnt = 0;
      for (int r = 0; r < 3; r++) begin
         tick();
         m_arready = 1'b1;
         tick();
         m_arready = 1'b0;
         for (int k = 0; k < 4; k++) tick();
      end
      check("ctrl_pops", 64'(pop_cnt), 64'd3);
      check("ctrl_count", 64'(count), 64'd0);

      // Simultaneous push and pop at count=2; pointers wrap more than twice.
      push_n(32'h200, 2);
      for (int i = 2; i < 12; i++) begin
         s_arvalid = 1'b1;
         s_araddr  = 32'h200 + ADDR_WIDTH'(4 * i);
         m_arready = 1'b1;
         tick();
         check("pp_count", 64'(count), 64'd2);
      end
      s_arvalid = 1'b0;
      drain();
      check("pp_empty", 64'(count), 64'd0);

      // Push into empty: visible on the very next cycle, then popped.
      s_arvalid = 1'b1;
      s_araddr  = 32'h500;
      tick();
      s_arvalid = 1'b0;
      check("bypass_valid", 64'(m_arvalid), 64'd1);
      check("bypass_addr", 64'(m_araddr), 64'h500);
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      check("bypass_pop_count", 64'(count), 64'd0);

      // Reset with three requests queued.
      push_n(32'h600, 3);
      check("pre_rst_count", 64'(count), 64'd3);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_valid", 64'(m_arvalid), 64'd0);
      check("mid_rst_ready", 64'(s_arready), 64'd1);
      push_n(32'h300, 1);
      check("post_rst_addr", 64'(m_araddr), 64'h300);
      check("post_rst_valid", 64'(m_arvalid), 64'd1);
      drain();

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         s_arvalid = 1'($urandom_range(0, 1));
         s_araddr  = $urandom;
         m_arready = ($urandom_range(0, 3) == 0);
         aresetn   = ($urandom_range(0, 299) != 0);
         tick();
      end
      aresetn   = 1'b1;
      s_arvalid = 1'b0;
      drain();
      check("final_count", 64'(count), 64'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
